// File: rtl/sram_param_if.sv
// Request/response bus of the parameterised SRAM.
// The master issues requests; the slave (the SRAM) answers read data and errors.
interface sram_param_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  rw;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     din;
    logic [DATA_W/8-1:0]   wbe;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     dataout;
    logic                  err;

    modport master (
        output req_valid, rw, addr, din, wbe,
        input  req_ready, rsp_valid, dataout, err
    );

    modport slave (
        input  req_valid, rw, addr, din, wbe,
        output req_ready, rsp_valid, dataout, err
    );
endinterface

// File: rtl/sram_param.sv
// Single-port SRAM with byte write enables, a zeroing sweep after reset or clear,
// one-cycle read latency and an error pulse for addresses beyond DEPTH.
module sram_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    output logic         init_done,
    sram_param_if.slave  bus
);
    localparam int                NB      = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        INIT = 1'b0,
        IDLE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                rsp_valid_q;
    logic                err_q;
    logic [DATA_W-1:0]   dout_q;
    logic                ready;
    logic                acc;
    logic                in_range;

    // Zero-extend so the compare also works when DEPTH == 2**ADDR_W.
    assign in_range = ({1'b0, bus.addr} < DEPTH_L);
    assign acc      = bus.req_valid && ready;

    assign bus.req_ready = ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.err       = err_q;
    assign bus.dataout   = dout_q;

    // State and sweep counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: sweep one word per cycle in INIT; clear restarts the sweep from IDLE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ready     = 1'b0;
        init_done = 1'b0;
        case (state_q)
            INIT: begin
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            IDLE: begin
                ready     = 1'b1;
                init_done = 1'b1;
                if (clear) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Storage: no reset, contents become zero only through the sweep.
    // A write accepted together with clear lands first, then the sweep wipes it.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (state_q == INIT) begin
                mem_q[cnt_q] <= '0;
            end else if (acc && bus.rw && in_range) begin
                for (int b = 0; b < NB; b++) begin
                    if (bus.wbe[b]) mem_q[bus.addr][8*b +: 8] <= bus.din[8*b +: 8];
                end
            end
        end
    end

    // Response path: registered read data, out-of-range reads return zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rsp_valid_q <= 1'b0;
            err_q       <= 1'b0;
            dout_q      <= '0;
        end else begin
            rsp_valid_q <= acc && !bus.rw;
            err_q       <= acc && !in_range;
            if (acc && !bus.rw) dout_q <= in_range ? mem_q[bus.addr] : '0;
        end
    end
endmodule

// File: tb/tb_sram_param.sv
// Randomised scoreboard bench for sram_param (16-bit words, 12 of 16 addresses present).
module tb_sram_param;
    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 12;

    logic clk   = 1'b0;
    logic rst   = 1'b0;
    logic clear = 1'b0;
    logic init_done;

    sram_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    sram_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .init_done (init_done),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rv;
        logic          er;
        logic [DW-1:0] d;
        int            cyc;
    } exp_t;

    exp_t          q[$];
    exp_t          e_mon;
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] mdl [DEPTH];
    logic [DW-1:0] mdl_dout = '0;
    logic [DW-1:0] mon_hold = '0;
    bit            mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: pops the expected response due this cycle, otherwise demands quiet outputs.
    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() > 0 && q[0].cyc <= cyc) begin
                e_mon = q.pop_front();
                chk("response", {45'd0, bus.rsp_valid, bus.err, bus.dataout},
                    {45'd0, e_mon.rv, e_mon.er, e_mon.d});
                mon_hold = e_mon.d;
            end else begin
                chk("idle_outputs", {45'd0, bus.rsp_valid, bus.err, bus.dataout},
                    {47'd0, mon_hold});
            end
        end
    end

    task automatic model_zero();
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    endtask

    // Drive one request for one cycle and record what the memory should answer.
    task automatic issue(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [1:0] be);
        exp_t e;
        bus.req_valid = 1'b1;
        bus.rw        = w;
        bus.addr      = a;
        bus.din       = d;
        bus.wbe       = be;
        e.cyc = cyc + 1;
        e.rv  = 1'b0;
        e.er  = 1'b0;
        e.d   = mdl_dout;
        if (int'(a) >= DEPTH) begin
            e.er = 1'b1;
            if (!w) begin
                e.rv     = 1'b1;
                mdl_dout = '0;
                e.d      = '0;
            end
            q.push_back(e);
        end else if (w) begin
            for (int b = 0; b < 2; b++) if (be[b]) mdl[a][8*b +: 8] = d[8*b +: 8];
        end else begin
            e.rv     = 1'b1;
            mdl_dout = mdl[a];
            e.d      = mdl_dout;
            q.push_back(e);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Count cycles with req_ready low while throwing junk requests and clears at the DUT.
    task automatic wait_init(input string nm);
        int n = 0;
        while (!bus.req_ready && n < 100) begin
            bus.req_valid = 1'($urandom);
            bus.rw        = 1'($urandom);
            bus.addr      = AW'($urandom);
            bus.din       = DW'($urandom);
            bus.wbe       = 2'($urandom);
            clear         = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
            n++;
        end
        bus.req_valid = 1'b0;
        clear         = 1'b0;
        chk({nm, "_init_cycles"}, 64'(n), 64'd12);
        chk({nm, "_init_done"}, {63'd0, init_done}, 64'd1);
        model_zero();
    endtask

    task automatic do_reset();
        q.delete();
        rst = 1'b0;
        @(posedge clk); #1;
        mon_hold = '0;
        mdl_dout = '0;
        chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd0);
        chk("rst_init_done", {63'd0, init_done}, 64'd0);
        chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        chk("rst_err", {63'd0, bus.err}, 64'd0);
        chk("rst_dataout", {48'd0, bus.dataout}, 64'd0);
        rst = 1'b1;
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) issue(1'b0, AW'(a), '0, 2'b00);
        idle(2);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.rw        = 1'b0;
        bus.addr      = '0;
        bus.din       = '0;
        bus.wbe       = '0;
        model_zero();
        do_reset();
        mon_en = 1'b1;
        wait_init("boot");
        read_all();

        // Byte-enable merge and read latency.
        issue(1'b1, 4'd3, 16'hA5C3, 2'b11);
        issue(1'b1, 4'd3, 16'hFFFF, 2'b01);
        issue(1'b0, 4'd3, '0, 2'b00);
        idle(2);

        // Read right after write, then streaming reads.
        issue(1'b1, 4'd5, 16'h1234, 2'b11);
        issue(1'b0, 4'd5, '0, 2'b00);
        read_all();

        // wbe = 0 leaves the word alone.
        issue(1'b1, 4'd7, 16'hDEAD, 2'b00);
        issue(1'b0, 4'd7, '0, 2'b00);
        idle(1);

        // Out-of-range accesses.
        issue(1'b1, 4'd13, 16'hBEEF, 2'b11);
        issue(1'b0, 4'd13, '0, 2'b00);
        issue(1'b0, 4'd15, '0, 2'b00);
        idle(1);
        read_all();

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0)
                issue(1'($urandom), AW'($urandom), DW'($urandom), 2'($urandom));
            else
                idle(1);
        end
        idle(2);

        // Fill, then clear with a concurrent write to address 0.
        for (int a = 0; a < DEPTH; a++) issue(1'b1, AW'(a), 16'h5555, 2'b11);
        read_all();
        clear = 1'b1;
        issue(1'b1, 4'd0, 16'h1111, 2'b11);
        clear = 1'b0;
        bus.req_valid = 1'b0;
        wait_init("clear");
        read_all();

        // Reset in the middle of the sweep.
        do_reset();
        repeat (6) begin @(posedge clk); #1; end
        do_reset();
        wait_init("midinit");
        read_all();

        // Reset in the middle of traffic.
        for (int a = 0; a < DEPTH; a++) issue(1'b1, AW'(a), DW'($urandom), 2'b11);
        do_reset();
        wait_init("midtraffic");
        read_all();

        idle(3);
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
